// File: rtl/alu_seq.sv
// Sequential datapath ALU: registered result with carry/overflow flags, shift/rotate,
// add-with-carry and an iterative shift-add unsigned multiplier driving a tri-state bus.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_negative,
  output logic             o_nZero,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_done,
  input  logic             i_aluWr,
  input  logic             i_noe,
  input  logic             i_subShiftDir,
  input  logic [2:0]       i_aluOp
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_ROT   = 3'b100;
  localparam logic [2:0] OP_ADC   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_MOVHI = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     r_y, r_hi;
  logic                 r_c, r_v, r_done;
  logic [2*WIDTH-1:0]   m_cand, m_acc, step_sum;
  logic [WIDTH-1:0]     m_plier;
  logic [SW-1:0]        m_cnt;

  logic [WIDTH-1:0]     bx, alu_y;
  logic                 alu_c, alu_v, accept, mul_start, mul_last;
  logic [WIDTH+1:0]     sum_ab, sum_adc;
  logic [WIDTH:0]       sh;
  logic [WIDTH-1:0]     rot;

  // Returns {overflow, carry, sum}.
  function automatic logic [WIDTH+1:0] add_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             cin);
    logic [WIDTH:0] s;
    logic           v;
    s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {v, s};
  endfunction

  // Returns {last bit shifted out, result}; the guard bit is zero when n = 0.
  function automatic logic [WIDTH:0] shift_op(input logic [WIDTH-1:0] a,
                                              input logic [SW-1:0]    n,
                                              input logic             left);
    logic [WIDTH:0] t;
    if (left) begin
      t = {1'b0, a} << n;
      return t;
    end
    t = {a, 1'b0} >> n;
    return {t[0], t[WIDTH:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotate_op(input logic [WIDTH-1:0] a,
                                                 input logic [SW-1:0]    n,
                                                 input logic             left);
    logic [2*WIDTH-1:0] t;
    if (left) begin
      t = {a, a} << n;
      return t[2*WIDTH-1:WIDTH];
    end
    t = {a, a} >> n;
    return t[WIDTH-1:0];
  endfunction

  assign bx        = i_b ^ {WIDTH{i_subShiftDir}};
  assign accept    = i_aluWr && (state == S_IDLE);
  assign mul_start = accept && (i_aluOp == OP_MUL);
  assign mul_last  = (state == S_MUL) && (m_cnt == CNT_LAST);
  assign step_sum  = m_acc + (m_plier[0] ? m_cand : '0);

  assign sum_ab  = add_op(i_a, bx, i_subShiftDir);
  assign sum_adc = add_op(i_a, bx, r_c);
  assign sh      = shift_op(i_a, i_b[SW-1:0], i_subShiftDir);
  assign rot     = rotate_op(i_a, i_b[SW-1:0], i_subShiftDir);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mul_start) state_nxt = S_MUL;
      S_MUL:   if (m_cnt == CNT_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_y = r_y;
    alu_c = r_c;
    alu_v = r_v;
    case (i_aluOp)
      OP_ADD:   {alu_v, alu_c, alu_y} = sum_ab;
      OP_ADC:   {alu_v, alu_c, alu_y} = sum_adc;
      OP_AND:   begin alu_y = i_a & bx; alu_c = 1'b0; alu_v = 1'b0; end
      OP_XOR:   begin alu_y = i_a ^ bx; alu_c = 1'b0; alu_v = 1'b0; end
      OP_SHIFT: begin {alu_c, alu_y} = sh; alu_v = 1'b0; end
      OP_ROT:   begin alu_y = rot; alu_c = 1'b0; alu_v = 1'b0; end
      OP_MOVHI: alu_y = r_hi;
      default:  ;
    endcase
  end

  // Control and architectural state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      m_cnt  <= '0;
      r_y    <= '0;
      r_hi   <= '0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      r_done <= mul_last;
      if (mul_start)
        m_cnt <= '0;
      else if (state == S_MUL)
        m_cnt <= m_cnt + 1'b1;
      if (accept && (i_aluOp != OP_MUL)) begin
        r_y <= alu_y;
        r_c <= alu_c;
        r_v <= alu_v;
      end
      if (mul_last) begin
        r_y  <= step_sum[WIDTH-1:0];
        r_hi <= step_sum[2*WIDTH-1:WIDTH];
        r_c  <= |step_sum[2*WIDTH-1:WIDTH];
        r_v  <= 1'b0;
      end
    end
  end

  // Multiplier datapath: one shift-add step per cycle while in S_MUL
  always_ff @(posedge i_clk) begin
    if (mul_start) begin
      m_cand  <= {{WIDTH{1'b0}}, i_a};
      m_plier <= i_b;
      m_acc   <= '0;
    end else if (state == S_MUL) begin
      m_acc   <= step_sum;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
    end
  end

  assign o_y        = i_noe ? {WIDTH{1'bz}} : r_y;
  assign o_negative = r_y[WIDTH-1];
  assign o_nZero    = |r_y;
  assign o_carry    = r_c;
  assign o_overflow = r_v;
  assign o_busy     = (state == S_MUL);
  assign o_done     = r_done;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised next-generation datapath ALU: WIDTH-bit operands, registered result, tri-stated bus output (active-low output enable).
- Adds carry and overflow flags, rotate, add-with-carry, and an iterative shift-add unsigned multiplier with a busy/done handshake.
- Sits between the register file (i_a, i_b) and the shared data bus (o_y).
- The control unit drives the op, write and output-enable strobes.

Parameters:
- WIDTH, 8, operand/result width; power of two, at least 4. SW = log2(WIDTH) is derived internally as the shift-amount width.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous active-high reset
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B; shift/rotate amount = i_b[SW-1:0], upper bits ignored
- o_y  out  WIDTH  r_y when i_noe=0, high-Z when i_noe=1
- o_negative  out  1  r_y[WIDTH-1]
- o_nZero  out  1  OR-reduction of r_y
- o_carry  out  1  registered carry flag r_c
- o_overflow  out  1  registered signed-overflow flag r_v
- o_busy  out  1  multiply in progress
- o_done  out  1  one-cycle pulse after a multiply result is written
- i_aluWr  in  1  issue/write strobe
- i_noe  in  1  active-low bus output enable
- i_subShiftDir  in  1  subtract (arith ops) / shift-rotate direction (1 = left, 0 = right)
- i_aluOp  in  3  operation select

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-high, on i_reset, and takes priority over everything. On reset r_y, r_hi, r_c and r_v clear to 0, the FSM goes to IDLE, o_busy=0 and o_done=0.
- Flag outputs: o_negative and o_nZero are combinational from r_y.
- Issue: an op is accepted on a rising edge when i_aluWr=1 and o_busy=0. i_aluWr while o_busy=1 is ignored, with no state change.
- Effective B (arith ops): bx = i_b XOR {WIDTH{i_subShiftDir}}.
- Single-cycle ops update r_y, r_c and r_v on the accepting edge:
  - 000 ADD/SUB: {c,y} = i_a + bx + i_subShiftDir. r_c = carry out (for SUB, 1 means no borrow). r_v = signed overflow, i.e. (a_msb == bx_msb) and (y_msb != a_msb).
  - 001 AND: y = i_a & bx; r_c=0, r_v=0.
  - 010 XOR: y = i_a ^ bx; r_c=0, r_v=0.
  - 011 SHIFT: logical shift of i_a by n = i_b[SW-1:0] in direction i_subShiftDir, zero fill. r_c = last bit shifted out (n=0 gives r_c=0). r_v=0.
  - 100 ROTATE: rotate i_a by n in direction i_subShiftDir; r_c=0, r_v=0.
  - 101 ADC/SBC: {c,y} = i_a + bx + r_c (uses the previous carry). r_c and r_v as for 000.
  - 111 MOVHI: r_y = r_hi; r_c and r_v unchanged.
- Multiply, 110 MUL (unsigned):
  - Accepting edge latches multiplicand = i_a and multiplier = i_b, clears the accumulator, counter=0, and moves the FSM IDLE->MUL. o_busy=1 from the next cycle.
  - In MUL, each edge does one shift-add step and increments the counter. On the WIDTH-th step edge:
    - r_y = product[WIDTH-1:0] and r_hi = product[2W-1:WIDTH];
    - r_c = (product high half != 0), r_v = 0;
    - FSM -> IDLE, o_busy -> 0, o_done = 1 for exactly the following cycle.
  - Latency: result is in r_y exactly WIDTH cycles after the accepting edge.
  - r_y, r_c and r_v hold their old values (and o_y shows the old r_y) throughout MUL.
- Back-to-back: i_aluWr asserted in the o_done cycle is accepted, since busy is already 0. o_done then still pulses exactly one cycle.
- Reset mid-multiply aborts: no result is written, o_done is not pulsed, and all state goes to reset values.
- r_hi is written only by MUL and by reset.
- i_noe affects only the output drive, never internal state.

Test Plan (WIDTH=8):
1. ADD 0x7F+0x01, sub=0 -> r_y=0x80, c=0, v=1, neg=1, nZero=1. Then SUB 0x00-0x01 -> 0xFF, c=0, v=0, neg=1.
2. ADD 0xFF+0x01 -> 0x00, c=1, nZero=0. Then ADC 0x00+0x00 -> 0x01, c=0. Then SBC 0x05-0x03 with c=0 -> 0x01, c=1.
3. SHIFT right 0x81 by 1 -> 0x40, c=1. SHIFT left 0x81 by 3 -> 0x08, c=0. SHIFT by n=0 -> 0x81, c=0. ROTATE left 0x81 by 1 -> 0x03. ROTATE right 0x81 by 4 -> 0x18. i_b=0x09 shifts by 1.
4. MUL 0xFF*0xFF -> o_busy high 8 cycles, r_y=0x01, c=1, single o_done pulse. ADD strobe at busy cycle 3 is ignored (r_y unchanged). Then MOVHI -> r_y=0xFE. Also MUL 0x0F*0x03 -> r_y=0x2D, c=0.
5. MUL issued, i_reset at busy cycle 4 -> next cycle busy=0, r_y=0x00, r_hi=0x00, flags 0, no o_done. A following MOVHI gives 0x00.
6. i_noe=1 -> o_y high-Z while flags still track r_y. Issuing MUL in the o_done cycle is accepted. Repeat scenarios 1 and 4 with WIDTH=16: 0xFFFF*0xFFFF -> low 0x0001, high 0xFFFE, 16-cycle busy.
